// File: rtl/center_of_mass.sv
// Per-frame centroid stage: accumulates qualifying pixels and issues x_sum/count and y_sum/count to the shared divider.
// Optional COM_ROUND_EN: round the centroid to nearest instead of truncating.
//
// state  | meaning
// IDLE   | accumulating; waiting for tabulate_in
// X_REQ  | x division request on the divider port
// X_WAIT | waiting for the x quotient
// Y_REQ  | y division request on the divider port
// Y_WAIT | waiting for the y quotient
module center_of_mass #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [10:0]      x_in,
    input  logic [9:0]       y_in,
    input  logic             valid_in,
    input  logic             tabulate_in,
    output logic [10:0]      x_out,
    output logic [9:0]       y_out,
    output logic             valid_out,
    output logic             busy_out,
    output logic [WIDTH-1:0] div_dividend_out,
    output logic [WIDTH-1:0] div_divisor_out,
    output logic             div_valid_out,
    input  logic [WIDTH-1:0] div_quotient_in,
    input  logic [WIDTH-1:0] div_remainder_in,
    input  logic             div_valid_in,
    input  logic             div_error_in
);

    typedef enum logic [2:0] {
        IDLE,
        X_REQ,
        X_WAIT,
        Y_REQ,
        Y_WAIT
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] x_sum, y_sum, count;
    logic [WIDTH-1:0] x_total, y_total, count_total;
    logic [WIDTH-1:0] y_snap;
    logic [10:0]      x_res;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             clear;
    logic             unused_bits;

    // Totals include the current pixel so a same-cycle pixel lands in the snapshot.
    assign x_total     = x_sum + (valid_in ? WIDTH'(x_in) : '0);
    assign y_total     = y_sum + (valid_in ? WIDTH'(y_in) : '0);
    assign count_total = count + WIDTH'(valid_in);

`ifdef COM_ROUND_EN
    logic [WIDTH:0] rem_x2;
    assign rem_x2      = {div_remainder_in, 1'b0};
    // The divisor port still holds the count snapshot while waiting for the result.
    assign quotient    = div_quotient_in + WIDTH'(rem_x2 >= {1'b0, div_divisor_out});
    assign unused_bits = ^result[WIDTH-1:11];
`else
    assign quotient    = div_quotient_in;
    assign unused_bits = ^{result[WIDTH-1:11], div_remainder_in};
`endif

    assign result = div_error_in ? '0 : quotient;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        clear      = 1'b0;
        case (state)
            IDLE: begin
                if (tabulate_in) begin
                    clear = 1'b1;
                    if (count_total != '0) begin
                        accept     = 1'b1;
                        state_next = X_REQ;
                    end
                end
            end
            X_REQ:   state_next = X_WAIT;
            X_WAIT:  if (div_valid_in) state_next = Y_REQ;
            Y_REQ:   state_next = Y_WAIT;
            Y_WAIT:  if (div_valid_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_sum <= '0;
            y_sum <= '0;
            count <= '0;
        end else if (clear) begin
            x_sum <= '0;
            y_sum <= '0;
            count <= '0;
        end else begin
            x_sum <= x_total;
            y_sum <= y_total;
            count <= count_total;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_out            <= '0;
            y_out            <= '0;
            valid_out        <= 1'b0;
            busy_out         <= 1'b0;
            div_dividend_out <= '0;
            div_divisor_out  <= '0;
            div_valid_out    <= 1'b0;
            y_snap           <= '0;
            x_res            <= '0;
        end else begin
            valid_out     <= 1'b0;
            div_valid_out <= 1'b0;
            // Busy stays up through the valid_out cycle, dropping one cycle after the y result.
            busy_out      <= (state_next != IDLE) || (state == Y_WAIT && div_valid_in);
            if (accept) begin
                y_snap           <= y_total;
                div_dividend_out <= x_total;
                div_divisor_out  <= count_total;
                div_valid_out    <= 1'b1;
            end
            if (state == X_WAIT && div_valid_in) begin
                x_res            <= result[10:0];
                div_dividend_out <= y_snap;
                div_valid_out    <= 1'b1;
            end
            if (state == Y_WAIT && div_valid_in) begin
                x_out     <= x_res;
                y_out     <= result[9:0];
                valid_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_center_of_mass.sv
// Directed bench for center_of_mass with a frame-level centroid model and a divider model.
// Build with COM_ROUND_EN defined to exercise the rounding variant.
module tb_center_of_mass;

    localparam int WIDTH = 32;
`ifdef COM_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic [10:0]      x_in = '0;
    logic [9:0]       y_in = '0;
    logic             valid_in = 1'b0;
    logic             tabulate_in = 1'b0;
    logic [10:0]      x_out;
    logic [9:0]       y_out;
    logic             valid_out;
    logic             busy_out;
    logic [WIDTH-1:0] div_dividend_out;
    logic [WIDTH-1:0] div_divisor_out;
    logic             div_valid_out;
    logic [WIDTH-1:0] div_quotient_in = '0;
    logic [WIDTH-1:0] div_remainder_in = '0;
    logic             div_valid_in = 1'b0;
    logic             div_error_in = 1'b0;

    center_of_mass #(.WIDTH(WIDTH)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .x_in(x_in),
        .y_in(y_in),
        .valid_in(valid_in),
        .tabulate_in(tabulate_in),
        .x_out(x_out),
        .y_out(y_out),
        .valid_out(valid_out),
        .busy_out(busy_out),
        .div_dividend_out(div_dividend_out),
        .div_divisor_out(div_divisor_out),
        .div_valid_out(div_valid_out),
        .div_quotient_in(div_quotient_in),
        .div_remainder_in(div_remainder_in),
        .div_valid_in(div_valid_in),
        .div_error_in(div_error_in)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, longint act, longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Frame-level model: running sums, pending divider requests, pending centroids.
    longint acc_x = 0, acc_y = 0, acc_n = 0;
    bit     model_busy = 1'b0;
    longint req_dd_q[$], req_dv_q[$];
    longint res_x_q[$], res_y_q[$];
    longint held_x = 0, held_y = 0;
    int     n_results = 0;
    int     n_reqs = 0;

    function automatic longint centroid(longint s, longint n);
        if (ROUND) return (2 * s + n) / (2 * n);
        return s / n;
    endfunction

    // Divider model with programmable latency.
    int          div_lat = 3;
    int          pend = 0;
    logic [31:0] p_dd = '0, p_dv = '0;

    always @(negedge clk_in) begin
        div_valid_in = 1'b0;
        div_error_in = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                div_valid_in     = 1'b1;
                div_error_in     = (p_dv == 0);
                div_quotient_in  = (p_dv == 0) ? '1 : p_dd / p_dv;
                div_remainder_in = (p_dv == 0) ? p_dd : p_dd % p_dv;
            end
        end
        if (div_valid_out === 1'b1 && !rst_in) begin
            p_dd = div_dividend_out;
            p_dv = div_divisor_out;
            pend = div_lat;
        end
    end

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (div_valid_out) begin
                n_reqs++;
                check("div_req_expected", longint'(req_dd_q.size() != 0), 1);
                if (req_dd_q.size() != 0) begin
                    check("div_dividend", div_dividend_out, req_dd_q.pop_front());
                    check("div_divisor", div_divisor_out, req_dv_q.pop_front());
                end
            end
            if (valid_out) begin
                n_results++;
                model_busy = 1'b0;
                check("valid_out_expected", longint'(res_x_q.size() != 0), 1);
                if (res_x_q.size() != 0) begin
                    held_x = res_x_q.pop_front();
                    held_y = res_y_q.pop_front();
                end
            end
            check("x_out", x_out, held_x);
            check("y_out", y_out, held_y);
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pixel(int x, int y);
        x_in     = 11'(x);
        y_in     = 10'(y);
        valid_in = 1'b1;
        acc_x += x;
        acc_y += y;
        acc_n += 1;
        step();
        valid_in = 1'b0;
    endtask

    task automatic tab(bit with_pix, int x, int y);
        longint tx, ty, tn;
        tabulate_in = 1'b1;
        if (with_pix) begin
            x_in     = 11'(x);
            y_in     = 10'(y);
            valid_in = 1'b1;
        end
        tx = acc_x + (with_pix ? x : 0);
        ty = acc_y + (with_pix ? y : 0);
        tn = acc_n + (with_pix ? 1 : 0);
        if (!model_busy) begin
            if (tn != 0) begin
                req_dd_q.push_back(tx); req_dv_q.push_back(tn);
                req_dd_q.push_back(ty); req_dv_q.push_back(tn);
                res_x_q.push_back(centroid(tx, tn) % 2048);
                res_y_q.push_back(centroid(ty, tn) % 1024);
                model_busy = 1'b1;
            end
            acc_x = 0; acc_y = 0; acc_n = 0;
        end else begin
            acc_x = tx; acc_y = ty; acc_n = tn;
        end
        step();
        tabulate_in = 1'b0;
        valid_in    = 1'b0;
    endtask

    task automatic wait_result(string name);
        int t = 0;
        while (!valid_out && t < 300) begin
            step();
            t++;
        end
        check({name, "_result_seen"}, valid_out, 1);
    endtask

    task automatic check_reset(string name);
        check({name, "_x_out"}, x_out, 0);
        check({name, "_y_out"}, y_out, 0);
        check({name, "_valid_out"}, valid_out, 0);
        check({name, "_busy_out"}, busy_out, 0);
        check({name, "_div_valid_out"}, div_valid_out, 0);
        check({name, "_div_dividend"}, div_dividend_out, 0);
        check({name, "_div_divisor"}, div_divisor_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int base;
        int t;
        rst_in = 1'b1;
        repeat (3) step();
        rst_in = 1'b0;
        check_reset("reset");

        // Three pixels: 34/3 and 63/3 give (11,21) in both modes.
        pixel(10, 20);
        pixel(11, 20);
        pixel(13, 23);
        tab(1'b0, 0, 0);
        check("tab_div_valid_out", div_valid_out, 1);
        check("tab_busy_rise", busy_out, 1);
        check("tab_div_dividend", div_dividend_out, 34);
        wait_result("basic");
        check("basic_x_lit", x_out, 11);
        check("basic_y_lit", y_out, 21);
        check("basic_busy_in_valid", busy_out, 1);
        step();
        check("basic_valid_pulse", valid_out, 0);
        check("basic_busy_fall", busy_out, 0);

        // 1/2 on both axes separates truncation from rounding.
        pixel(0, 0);
        pixel(1, 1);
        tab(1'b0, 0, 0);
        wait_result("half");
        check("half_x_lit", x_out, ROUND ? 1 : 0);
        check("half_y_lit", y_out, ROUND ? 1 : 0);
        step();

        tab(1'b0, 0, 0);
        check("empty_no_req", div_valid_out, 0);
        repeat (10) step();
        check("empty_x_held", x_out, ROUND ? 1 : 0);
        check("empty_no_valid", valid_out, 0);

        // Pixels and an ignored tabulate while the x division is pending.
        div_lat = 6;
        pixel(1, 2);
        pixel(3, 4);
        tab(1'b0, 0, 0);
        pixel(5, 6);
        tab(1'b0, 0, 0);
        pixel(7, 8);
        wait_result("busy_a");
        check("busy_a_x_lit", x_out, 2);
        check("busy_a_y_lit", y_out, 3);
        step();
        tab(1'b0, 0, 0);
        wait_result("busy_b");
        check("busy_b_x_lit", x_out, 6);
        check("busy_b_y_lit", y_out, 7);
        step();
        div_lat = 3;

        tab(1'b1, 100, 50);
        wait_result("same_cycle");
        check("same_cycle_x_lit", x_out, 100);
        check("same_cycle_y_lit", y_out, 50);
        step();
        tab(1'b0, 0, 0);
        check("next_frame_empty", div_valid_out, 0);
        repeat (8) step();

        // Coordinate extremes: 4093/2 and 2045/2.
        pixel(2047, 1023);
        pixel(2046, 1022);
        tab(1'b0, 0, 0);
        wait_result("edge");
        check("edge_x_lit", x_out, ROUND ? 2047 : 2046);
        check("edge_y_lit", y_out, ROUND ? 1023 : 1022);
        step();

        // Reset while waiting for the y quotient; its late result must be ignored.
        div_lat = 10;
        pixel(10, 20);
        pixel(11, 20);
        pixel(13, 23);
        base = n_reqs;
        tab(1'b0, 0, 0);
        t = 0;
        while (n_reqs < base + 2 && t < 100) begin
            step();
            t++;
        end
        check("abort_y_req_seen", n_reqs, base + 2);
        repeat (3) step();
        rst_in = 1'b1;
        req_dd_q.delete(); req_dv_q.delete();
        res_x_q.delete(); res_y_q.delete();
        acc_x = 0; acc_y = 0; acc_n = 0;
        model_busy = 1'b0;
        held_x = 0; held_y = 0;
        step();
        step();
        rst_in = 1'b0;
        check_reset("abort");
        base = n_results;
        repeat (15) step();
        check("abort_no_result", n_results, base);
        check("abort_x_zero", x_out, 0);
        div_lat = 3;
        pixel(5, 7);
        tab(1'b0, 0, 0);
        wait_result("after_abort");
        check("after_abort_x_lit", x_out, 5);
        check("after_abort_y_lit", y_out, 7);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
